// File: rtl/sample_loader_pkg.sv
// Shared definitions for the sample loader: bus widths, FSM encoding, counter sizing.
// No logic of its own; only constants, types and an elaboration-time helper.
// Not applicable (no datapath, no flow control).
package sample_loader_pkg;

    localparam int MEM_ADDR_LEN  = 15;
    localparam int REG_WORD_LEN  = 16;
    localparam int FRAME_CNT_LEN = 16;

    typedef enum logic [1:0] {
        LOADER_STATE_IDLE  = 2'd0,
        LOADER_STATE_FILL  = 2'd1,
        LOADER_STATE_FLUSH = 2'd2,
        LOADER_STATE_RUN   = 2'd3
    } loader_state_t;

    // Width of a counter spanning 0..frame_len-1; never narrower than one bit.
    function automatic int sample_cnt_width(input int frame_len);
        return (frame_len <= 2) ? 1 : $clog2(frame_len);
    endfunction

endpackage

// File: rtl/sample_addr_gen.sv
// Loadable bank address / sample counter with terminal-count flag for one frame.
// Address and count update on the edge after load/inc; last is combinational on count.
// No flow control; the owner decides when to increment.
module sample_addr_gen
    import sample_loader_pkg::*;
#(
    parameter logic [MEM_ADDR_LEN-1:0] BASE_ADDR = '0,
    parameter int                      FRAME_LEN = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    inc,
    output logic [MEM_ADDR_LEN-1:0] addr,
    output logic                    last
);

    localparam int                CNT_W    = sample_cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // Address wraps modulo the bank size; count wraps back to zero after the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= BASE_ADDR;
            cnt  <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
            cnt  <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/sample_loader.sv
// Captures one frame from a valid/ready stream into bank I, then releases the DSP until done.
// Write strobe 1 cycle after each handshake; DSP released 2 cycles after the last handshake.
// s_ready is high only while filling; upstream stalls are absorbed indefinitely.
module sample_loader
    import sample_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int FRAME_LEN = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [REG_WORD_LEN-1:0]  s_data,
    output logic                     s_ready,
    output logic [MEM_ADDR_LEN-1:0]  write_addr_1,
    output logic [REG_WORD_LEN-1:0]  write_data_1,
    output logic                     write_en_1,
    output logic                     dsp_rst,
    input  logic                     dsp_done,
    output logic                     busy,
    output logic [FRAME_CNT_LEN-1:0] frame_cnt
);

    loader_state_t           state;
    logic [MEM_ADDR_LEN-1:0] cur_addr;
    logic                    cnt_last;
    logic                    hs;
    logic                    addr_load;

    // s_ready is registered and only set in FILL, so it alone qualifies the handshake.
    assign hs        = s_valid & s_ready;
    assign addr_load = (state == LOADER_STATE_IDLE) & start;

    sample_addr_gen #(
        .BASE_ADDR (MEM_ADDR_LEN'(BASE_ADDR)),
        .FRAME_LEN (FRAME_LEN)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (addr_load),
        .inc  (hs),
        .addr (cur_addr),
        .last (cnt_last)
    );

    // Frame FSM with all outputs registered; the write strobe is a one-cycle pulse per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOADER_STATE_IDLE;
            s_ready      <= 1'b0;
            write_en_1   <= 1'b0;
            write_addr_1 <= '0;
            write_data_1 <= '0;
            dsp_rst      <= 1'b1;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            write_en_1 <= 1'b0;
            case (state)
                LOADER_STATE_IDLE: begin
                    if (start) begin
                        state   <= LOADER_STATE_FILL;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LOADER_STATE_FILL: begin
                    if (hs) begin
                        write_en_1   <= 1'b1;
                        write_addr_1 <= cur_addr;
                        write_data_1 <= s_data;
                        if (cnt_last) begin
                            state   <= LOADER_STATE_FLUSH;
                            s_ready <= 1'b0;
                        end
                    end
                end
                LOADER_STATE_FLUSH: begin
                    // Final write is on the bus this cycle; release the DSP only afterwards.
                    state   <= LOADER_STATE_RUN;
                    dsp_rst <= 1'b0;
                end
                LOADER_STATE_RUN: begin
                    if (dsp_done) begin
                        state     <= LOADER_STATE_IDLE;
                        dsp_rst   <= 1'b1;
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: state <= LOADER_STATE_IDLE;
            endcase
        end
    end

endmodule
